// File: rtl/prbs_ber_scan_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_ber_scan_ctrl
//
// Sequencer for a PRBS7 alignment/checker datapath. A start command pulses
// the extractor reset, waits (with timeout) for alignment lock, discards the
// checker pipeline latency, then accumulates per-word error counts over a
// programmed window and reports the totals and lock status.
//
// Optional feature: define BER_SCAN_PEAK_EN to track the largest single-word
// error count seen during the measurement window on err_peak. When it is not
// defined, err_peak is tied to zero and no comparator is built.
//
// Parameters
//   WINDOW_W  width of the measurement-window length (words)
//   ERR_W     width of the saturating error accumulator
//   TIMEOUT   maximum number of WAIT cycles before lock failure
//   SETTLE    post-lock cycles discarded to flush the checker pipeline
//
// Ports
//   clk          extractor clock
//   reset        synchronous, active-high
//   start        one-cycle request, honoured only in IDLE
//   abort        return to IDLE from any state, counters/flags hold
//   window_len   words to measure, latched on an accepted start (0 -> 1)
//   aligned      extractor lock status
//   error_count  per-word error count from the checker (0..32)
//   ext_reset    reset to the extractor
//   busy         high whenever the sequencer is not in IDLE
//   done         one-cycle completion pulse
//   lock_fail    sticky, lock timeout occurred
//   lost_lock    sticky, aligned dropped during MEAS
//   err_total    accumulated error bits, saturating
//   words_done   number of words accumulated
//   err_peak     largest single-word error count in the window
//   state        IDLE=0, RST=1, WAIT=2, SETL=3, MEAS=4, DONE=5
// ---------------------------------------------------------------------------
module prbs_ber_scan_ctrl #(
   parameter int WINDOW_W = 32,
   parameter int ERR_W    = 40,
   parameter int TIMEOUT  = 4096,
   parameter int SETTLE   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [WINDOW_W-1:0] window_len,
   input  logic                aligned,
   input  logic [5:0]          error_count,
   output logic                ext_reset,
   output logic                busy,
   output logic                done,
   output logic                lock_fail,
   output logic                lost_lock,
   output logic [ERR_W-1:0]    err_total,
   output logic [WINDOW_W-1:0] words_done,
   output logic [5:0]          err_peak,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_WAIT = 3'd2,
      S_SETL = 3'd3,
      S_MEAS = 3'd4,
      S_DONE = 3'd5
   } state_e;

   // The wait counter can sit at TIMEOUT after a lock on the final WAIT
   // cycle followed by a drop in SETL, so it needs room for that value.
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

   state_e              state_q, state_d;
   logic [1:0]          rst_cnt_q, rst_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
   logic [WINDOW_W-1:0] len_q, len_d;
   logic [WINDOW_W-1:0] words_done_q, words_done_d;
   logic [ERR_W-1:0]    err_total_q, err_total_d;
   logic                lock_fail_q, lock_fail_d;
   logic                lost_lock_q, lost_lock_d;
   logic                ext_reset_q, ext_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // One extra bit catches accumulator overflow for saturation.
   logic [ERR_W:0]      err_sum;
   logic [WINDOW_W-1:0] words_inc;

   assign err_sum   = {1'b0, err_total_q} + (ERR_W + 1)'(error_count);
   assign words_inc = words_done_q + WINDOW_W'(1);

`ifdef BER_SCAN_PEAK_EN
   logic [5:0] err_peak_q, err_peak_d;
`endif

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      settle_cnt_d = settle_cnt_q;
      len_d        = len_q;
      words_done_d = words_done_q;
      err_total_d  = err_total_q;
      lock_fail_d  = lock_fail_q;
      lost_lock_d  = lost_lock_q;
`ifdef BER_SCAN_PEAK_EN
      err_peak_d   = err_peak_q;
`endif

      // Abort is checked ahead of the state case so that nothing else
      // changes in that cycle: counters and flags simply hold.
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d      = S_RST;
                  len_d        = (window_len == '0) ? WINDOW_W'(1) : window_len;
                  words_done_d = '0;
                  err_total_d  = '0;
                  lock_fail_d  = 1'b0;
                  lost_lock_d  = 1'b0;
                  rst_cnt_d    = '0;
                  wait_cnt_d   = '0;
`ifdef BER_SCAN_PEAK_EN
                  err_peak_d   = '0;
`endif
               end
            end

            S_RST: begin
               rst_cnt_d = rst_cnt_q + 2'd1;
               if (rst_cnt_q == 2'd3) begin
                  state_d = S_WAIT;
               end
            end

            S_WAIT: begin
               if (wait_cnt_q < WAIT_MAX) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
               // Lock is tested first so it wins on the final timeout cycle.
               if (aligned) begin
                  state_d      = S_SETL;
                  settle_cnt_d = '0;
               end else if (wait_cnt_q >= WAIT_LAST) begin
                  lock_fail_d = 1'b1;
                  state_d     = S_DONE;
               end
            end

            S_SETL: begin
               // Losing lock here resumes WAIT without restarting the
               // timeout budget.
               if (!aligned) begin
                  state_d = S_WAIT;
               end else if (settle_cnt_q == SET_LAST) begin
                  state_d = S_MEAS;
               end else begin
                  settle_cnt_d = settle_cnt_q + SET_W'(1);
               end
            end

            S_MEAS: begin
               if (!aligned) begin
                  lost_lock_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  err_total_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                  words_done_d = words_inc;
`ifdef BER_SCAN_PEAK_EN
                  if (error_count > err_peak_q) begin
                     err_peak_d = error_count;
                  end
`endif
                  if (words_inc == len_q) begin
                     state_d = S_DONE;
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Status outputs are decoded from the next state and registered, so
      // they line up exactly with the state they describe.
      ext_reset_d = (state_d == S_RST);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         settle_cnt_q <= '0;
         len_q        <= '0;
         words_done_q <= '0;
         err_total_q  <= '0;
         lock_fail_q  <= 1'b0;
         lost_lock_q  <= 1'b0;
         ext_reset_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         len_q        <= len_d;
         words_done_q <= words_done_d;
         err_total_q  <= err_total_d;
         lock_fail_q  <= lock_fail_d;
         lost_lock_q  <= lost_lock_d;
         ext_reset_q  <= ext_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef BER_SCAN_PEAK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_peak_q <= '0;
      end else begin
         err_peak_q <= err_peak_d;
      end
   end
   assign err_peak = err_peak_q;
`else
   assign err_peak = '0;
`endif

   assign state      = state_q;
   assign ext_reset  = ext_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign lock_fail  = lock_fail_q;
   assign lost_lock  = lost_lock_q;
   assign err_total  = err_total_q;
   assign words_done = words_done_q;

endmodule

// File: doc/prbs_ber_scan_ctrl.md
# prbs_ber_scan_ctrl

Sequencer for the PRBS7 alignment/checker datapath. On a start command it resets the data extractor and waits for alignment lock, with a timeout. It then discards the checker's pipeline latency and accumulates per-word error counts over a programmed window, reporting totals and lock status. It sits between the control/register interface and the extractor: it drives the extractor's `reset` and consumes its `aligned` and `errorCounter` outputs.

## Interface
- `WINDOW_W`, 32: width of the measurement-window length, in words.
- `ERR_W`, 40: width of the error accumulator.
- `TIMEOUT`, 4096: maximum number of WAIT_LOCK cycles before lock failure is declared.
- `SETTLE`, 8: number of post-lock cycles discarded to flush the checker pipeline.
- `clk`  in  1  single clock, the extractor clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `window_len`  in  WINDOW_W  number of words to measure; latched on an accepted `start`.
- `aligned`  in  1  extractor lock status.
- `error_count`  in  6  per-word error count from the checker, range 0..32.
- `ext_reset`  out  1  reset to the extractor.
- `busy`  out  1  high when state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `lock_fail`  out  1  sticky; lock timeout occurred.
- `lost_lock`  out  1  sticky; `aligned` dropped during MEASURE.
- `err_total`  out  ERR_W  accumulated error bits; saturating.
- `words_done`  out  WINDOW_W  number of words accumulated.
- `err_peak`  out  6  maximum single-word `error_count` seen in the window (see Configuration).
- `state`  out  3  encoding: IDLE=0, RST=1, WAIT=2, SETL=3, MEAS=4, DONE=5.

## Operation
- **IDLE:** an accepted `start` latches `window_len`, clears `err_total`, `words_done`, `err_peak`, `lock_fail` and `lost_lock`, then goes to RST. A `window_len` of 0 is latched as 1.
- **RST:** `ext_reset` = 1 for exactly 4 cycles, then go to WAIT.
- **WAIT:** a wait counter increments each cycle.
  - `aligned` = 1 → go to SETL.
  - Counter reaches TIMEOUT−1 with `aligned` = 0 → set `lock_fail`, go to DONE.
  - If `aligned` = 1 on the final timeout cycle, lock wins.
- **SETL:** SETTLE cycles are discarded, then go to MEAS.
  - `aligned` = 0 during SETL → go back to WAIT. The wait counter is not reset.
- **MEAS:** each cycle, `err_total` += `error_count`, saturating at all-ones, and `words_done` += 1.
  - `words_done` reaching the latched length → go to DONE. The last accumulated word is included.
  - `aligned` = 0 → set `lost_lock` and go to DONE. The word of that cycle is not accumulated.
- **DONE:** `done` = 1 for one cycle, then go to IDLE. `start` in the DONE cycle is ignored.
- **abort:** from any state, next state is IDLE and `ext_reset` deasserts. No `done` pulse. Counters and flags hold their values.
  - `abort` and `start` in the same IDLE cycle: abort wins and `start` is dropped.
- `start` while `busy` is ignored, with no side effects.
- `reset` mid-operation: immediately to IDLE, same as the reset state.

## Timing
- Reset values: state=IDLE; `ext_reset`=0, `busy`=0, `done`=0, `lock_fail`=0, `lost_lock`=0, `err_total`=0, `words_done`=0, `err_peak`=0.
- All outputs are registered.
- `start` sampled at cycle T: `busy` is high at T+1, and `ext_reset` is high during T+1..T+4. The earliest WAIT cycle is T+5.
- `aligned` first seen high at cycle L: SETL runs L+1..L+SETTLE, and MEAS begins at L+SETTLE+1.
- MEAS with length N: `words_done`=N and DONE in the cycle after the N-th accumulation. `busy` drops the cycle after `done`.
- Timeout with no lock: `done` at T+5+TIMEOUT.

## Configuration
- `BER_SCAN_PEAK_EN` defined: during MEAS, `err_peak` <= max(`err_peak`, `error_count`). It is cleared on an accepted `start`.
- Not defined: `err_peak` is constant 0 and no comparator is synthesized.

## Test plan
- **Normal run:** `aligned` rises 10 cycles after RST ends, `window_len`=100, `error_count`=0 → `done` once, `err_total`=0, `words_done`=100, both flags 0.
- **Error accumulation:** `window_len`=16, `error_count`=3 every MEAS cycle → `err_total`=48. With the macro, `err_peak`=3; a single injected word of 32 → `err_peak`=32.
- **Lock timeout:** TIMEOUT=64, `aligned` held 0 → `lock_fail`=1, `done` at T+69, `words_done`=0.
- **Lost lock:** `aligned` drops at MEAS word 20 of 50 → `lost_lock`=1, `words_done`=20, `done` the next cycle.
- **Abort/collision:** `abort` during WAIT → IDLE next cycle, no `done`. `start`+`abort` together in IDLE → stays IDLE. `start` during MEAS → ignored.
- **Saturation and edges:** `ERR_W`=8 with `error_count`=32 for 10 words → `err_total`=255. `window_len`=0 → exactly 1 word measured.
